// File: rtl/conv_window_filter_if.sv
`default_nettype none
// ============================================================================
// conv_window_filter_if
// ----------------------------------------------------------------------------
// Valid/ready pixel stream bundle used on both sides of conv_window_filter.
//   data  : packed multi-channel pixel, W bits
//   valid : producer has a pixel on data
//   ready : consumer takes the pixel this cycle
// master drives data/valid, slave drives ready.
// Revision: 1.0 - initial release
// ============================================================================
interface conv_window_filter_if #(
  parameter int W = 30
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/conv_window_filter.sv
`default_nettype none
// ============================================================================
// conv_window_filter
// ----------------------------------------------------------------------------
// K x K streaming convolution over raster-ordered packed pixels, zero-padded
// at frame borders so output frame size equals input frame size. Each channel
// is convolved independently, arithmetically shifted and clamped to [0,2^CW-1].
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   h           : K*K signed BW-bit coefficients, row-major, h[0] top-left
//   shift       : arithmetic right shift applied to each accumulator
//   x (slave)   : input pixel stream
//   y (master)  : filtered pixel stream
//   frame_done  : pulses with the transfer of a frame's last output
// Revision: 1.0 - initial release
// ============================================================================
module conv_window_filter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int K      = 3,
  parameter int CH     = 3,
  parameter int CW     = 8,
  parameter int PAD    = 2,
  parameter int BW     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [K*K-1:0][BW-1:0]   h,
  input  logic [4:0]               shift,
  conv_window_filter_if.slave      x,
  conv_window_filter_if.master     y,
  output logic                     frame_done
);
  localparam int R    = K / 2;
  localparam int D    = R * WIDTH + R;
  localparam int FW   = CW + PAD;
  localparam int W    = CH * FW;
  localparam int NT   = K * K;
  localparam int SW   = CW + 1 + BW + $clog2(NT);
  localparam int COLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROWW = $clog2(HEIGHT + 1);
  localparam int DW   = $clog2(D + 1);
  localparam logic signed [SW-1:0] MAXS = SW'((1 << CW) - 1);

  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state_q;
  logic [COLW-1:0]        icol_q, ocol_q;
  logic [ROWW-1:0]        irow_q, orow_q;
  logic [DW-1:0]          cnt_q;
  logic [NT-1:0][BW-1:0]  h_q;
  logic [4:0]             shift_q;

  logic [W-1:0]           lb_q  [K-1][WIDTH];
  logic [W-1:0]           win_q [K][K];
  logic [W-1:0]           win_d [K][K];
  logic [W-1:0]           col_in [K];

  logic                   s1_valid_q, s1_last_q;
  logic [CH-1:0][SW-1:0]  s1_sum_q, sum_d;
  logic                   y_valid_q, y_last_q;
  logic [W-1:0]           y_data_q, y_data_d;

  logic                   adv, step, emit, in_last, out_last;
  logic [K-1:0]           rok, cok;
  logic [NT-1:0]          tap_ok;
  logic signed [SW-1:0]   w_a, w_b, w_acc, w_sh;

  // Everything (window, counters, both stages) moves together on adv.
  assign adv      = y.ready | ~y.valid;
  assign x.ready  = adv & (state_q != FLUSH);
  assign step     = adv & ((state_q == FLUSH) | x.valid);
  assign emit     = step & (state_q != FILL);
  assign in_last  = (irow_q == ROWW'(HEIGHT - 1)) && (icol_q == COLW'(WIDTH - 1));
  assign out_last = (orow_q == ROWW'(HEIGHT - 1)) && (ocol_q == COLW'(WIDTH - 1));

  // Column entering the window: bottom row is the new (or injected zero)
  // pixel, each row above is the same column one line earlier.
  always_comb begin
    col_in[K-1] = (state_q == FLUSH) ? '0 : x.data;
    for (int k = 0; k < K - 1; k++) col_in[k] = lb_q[k][icol_q];
    for (int r = 0; r < K; r++) begin
      for (int q = 0; q < K - 1; q++) win_d[r][q] = win_q[r][q+1];
      win_d[r][K-1] = col_in[r];
    end
  end

  // Line buffers and window carry no reset: stale contents are always masked.
  always_ff @(posedge clk) begin
    if (step) begin
      for (int k = 0; k < K - 1; k++) lb_q[k][icol_q] <= col_in[k+1];
      win_q <= win_d;
    end
  end

  // Border mask from the output coordinate of the window centre.
  always_comb begin
    rok = '0;
    cok = '0;
    tap_ok = '0;
    for (int r = 0; r < K; r++) begin
      rok[r] = (int'(orow_q) + r - R >= 0) && (int'(orow_q) + r - R < HEIGHT);
      cok[r] = (int'(ocol_q) + r - R >= 0) && (int'(ocol_q) + r - R < WIDTH);
    end
    for (int r = 0; r < K; r++)
      for (int q = 0; q < K; q++) tap_ok[r*K+q] = rok[r] & cok[q];
  end

  // Per-channel multiply-accumulate; channel value is zero-extended to signed.
  always_comb begin
    sum_d = '0;
    w_a   = '0;
    w_b   = '0;
    w_acc = '0;
    for (int c = 0; c < CH; c++) begin
      w_acc = '0;
      for (int r = 0; r < K; r++) begin
        for (int q = 0; q < K; q++) begin
          if (tap_ok[r*K+q]) begin
            w_a   = SW'($signed({1'b0, win_d[r][q][(c+1)*FW-1 -: CW]}));
            w_b   = SW'($signed(h_q[r*K+q]));
            w_acc = w_acc + w_a * w_b;
          end
        end
      end
      sum_d[c] = w_acc;
    end
  end

  // Scale and clamp; PAD bits of the output stay zero.
  always_comb begin
    y_data_d = '0;
    w_sh     = '0;
    for (int c = 0; c < CH; c++) begin
      w_sh = $signed(s1_sum_q[c]) >>> shift_q;
      if (w_sh < 0)
        y_data_d[(c+1)*FW-1 -: CW] = '0;
      else if (w_sh > MAXS)
        y_data_d[(c+1)*FW-1 -: CW] = '1;
      else
        y_data_d[(c+1)*FW-1 -: CW] = w_sh[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      y_valid_q  <= 1'b0;
      y_last_q   <= 1'b0;
      y_data_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= emit;
      s1_last_q  <= emit & out_last;
      s1_sum_q   <= sum_d;
      y_valid_q  <= s1_valid_q;
      y_last_q   <= s1_last_q;
      y_data_q   <= y_data_d;
    end
  end

  assign y.valid    = y_valid_q;
  assign y.data     = y_data_q;
  assign frame_done = y_valid_q & y.ready & y_last_q;

  // Sequencer: FILL primes the window, RUN emits one output per pixel,
  // FLUSH injects D zero pixels to drain the last rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      icol_q  <= '0;
      irow_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      cnt_q   <= '0;
      h_q     <= '0;
      shift_q <= '0;
    end else if (step) begin
      if (icol_q == COLW'(WIDTH - 1)) begin
        icol_q <= '0;
        if (state_q != FLUSH) irow_q <= irow_q + 1'b1;
      end else begin
        icol_q <= icol_q + 1'b1;
      end
      if (emit) begin
        if (ocol_q == COLW'(WIDTH - 1)) begin
          ocol_q <= '0;
          orow_q <= orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end
      case (state_q)
        FILL: begin
          // Kernel and shift are frozen for the frame at pixel n = 0.
          if (icol_q == '0 && irow_q == '0) begin
            h_q     <= h;
            shift_q <= shift;
          end
          if (cnt_q == DW'(D - 1)) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: if (in_last) state_q <= FLUSH;
        FLUSH: begin
          if (cnt_q == DW'(D - 1)) begin
            state_q <= FILL;
            cnt_q   <= '0;
            icol_q  <= '0;
            irow_q  <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule
`default_nettype wire
